// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP/bubble encoding, stage-bundle layouts and
// the control encoding for a single pipeline entry register.
package pipe_pkg;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned REG_W   = 32;
  localparam int unsigned CTRL_W  = 16;

  // IF/ID: {pc, instr}
  localparam int unsigned FD_INSTR_LSB = 0;
  localparam int unsigned FD_PC_LSB    = FD_INSTR_LSB + INSTR_W;
  localparam int unsigned FD_W         = FD_PC_LSB + PC_W;

  // ID/EX: {ctrl, rs2, rs1, pc}
  localparam int unsigned DE_PC_LSB   = 0;
  localparam int unsigned DE_RS1_LSB  = DE_PC_LSB + PC_W;
  localparam int unsigned DE_RS2_LSB  = DE_RS1_LSB + REG_W;
  localparam int unsigned DE_CTRL_LSB = DE_RS2_LSB + REG_W;
  localparam int unsigned DE_W        = DE_CTRL_LSB + CTRL_W;

  // EX/MEM: {ctrl, store data, alu result}
  localparam int unsigned EM_ALU_LSB  = 0;
  localparam int unsigned EM_STD_LSB  = EM_ALU_LSB + REG_W;
  localparam int unsigned EM_CTRL_LSB = EM_STD_LSB + REG_W;
  localparam int unsigned EM_W        = EM_CTRL_LSB + CTRL_W;

  // MEM/WB: {ctrl, writeback value}
  localparam int unsigned MW_WB_LSB   = 0;
  localparam int unsigned MW_CTRL_LSB = MW_WB_LSB + REG_W;
  localparam int unsigned MW_W        = MW_CTRL_LSB + CTRL_W;

  typedef enum logic [1:0] {
    ENT_HOLD  = 2'd0,
    ENT_LOAD  = 2'd1,
    ENT_CLEAR = 2'd2
  } entry_op_e;

endpackage

// File: rtl/pipe_entry.sv
// One valid+payload register. LOAD captures d_i, CLEAR reloads the bubble
// value and drops valid, HOLD keeps contents.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned     W       = 32,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  entry_op_e     op_i,
  input  logic [W-1:0]  d_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (op_i)
      ENT_LOAD: begin
        valid_d = 1'b1;
        data_d  = d_i;
      end
      ENT_CLEAR: begin
        valid_d = 1'b0;
        data_d  = RST_VAL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic pipeline stage register: valid/ready handshake, optional 2-entry
// skid, flush-to-bubble, hard stall and a saturating backpressure counter.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(PIPE_NOP),
  parameter int unsigned        SKID       = 1,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cnt
);

  entry_op_e         main_op, skid_op;
  logic [DATA_W-1:0] main_d;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, emit;
  logic [CNT_W-1:0]  bp_cnt_q, bp_cnt_d;

  assign out_valid = main_valid & ~stall;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready & ~flush;
  assign emit      = out_valid & out_ready;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Stall needs no explicit branch: it forces accept and emit low, so every
  // entry falls through to HOLD.
  always_comb begin
    main_op = ENT_HOLD;
    skid_op = ENT_HOLD;
    main_d  = in_data;
    if (flush) begin
      main_op = ENT_CLEAR;
      skid_op = ENT_CLEAR;
    end else if (SKID != 0) begin
      if (emit) begin
        if (skid_valid) begin
          main_op = ENT_LOAD;
          main_d  = skid_data;
          skid_op = ENT_CLEAR;
        end else if (accept) begin
          main_op = ENT_LOAD;
        end else begin
          main_op = ENT_CLEAR;
        end
      end else if (accept) begin
        if (main_valid) skid_op = ENT_LOAD;
        else            main_op = ENT_LOAD;
      end
    end else begin
      if (accept)    main_op = ENT_LOAD;
      else if (emit) main_op = ENT_CLEAR;
    end
  end

  pipe_entry #(.W(DATA_W), .RST_VAL(BUBBLE_VAL)) u_main (
    .CLK     (CLK),
    .RST     (RST),
    .op_i    (main_op),
    .d_i     (main_d),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q, in_ready_d;

    pipe_entry #(.W(DATA_W), .RST_VAL(BUBBLE_VAL)) u_skid (
      .CLK     (CLK),
      .RST     (RST),
      .op_i    (skid_op),
      .d_i     (in_data),
      .valid_o (skid_valid),
      .data_o  (skid_data)
    );

    // Registered copy of "skid will be empty", so in_ready never sees out_ready.
    assign in_ready_d = ~((skid_op == ENT_LOAD) | ((skid_op == ENT_HOLD) & skid_valid));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) in_ready_q <= 1'b1;
      else     in_ready_q <= in_ready_d;
    end

    assign in_ready = ~stall & in_ready_q;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_data  = BUBBLE_VAL;
    assign in_ready   = ~stall & (~main_valid | out_ready);
  end

  always_comb begin
    bp_cnt_d = bp_cnt_q;
    if (((stall & ~flush) | (out_valid & ~out_ready)) && (bp_cnt_q != '1))
      bp_cnt_d = bp_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bp_cnt_q <= '0;
    else     bp_cnt_q <= bp_cnt_d;
  end

  assign bp_cnt = bp_cnt_q;

endmodule
